// File: rtl/axis_join_pkg.sv
// Shared types for axis_join: FSM states, default widths, skid entry layout.
// No logic of its own; the saturating add is used by the drop counter.
// Widths here describe the default DATA_WIDTH=1 build.
package axis_join_pkg;

  localparam int DATA_WIDTH = 1;
  localparam int IN_W       = DATA_WIDTH * 8;
  localparam int OUT_W      = 2 * IN_W;

  typedef enum logic {JOIN, RESYNC} state_t;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
    logic             user;
  } skid_entry_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// 2-entry register slice; head entry drives the output directly.
// Latency: push visible on out_vld the next cycle.
// Backpressure: registered 'space' drops when both entries are occupied.
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             space,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;
  logic [1:0]       cnt;
  logic [1:0]       cnt_nxt;
  logic             push;
  logic             pop;

  assign push    = in_vld & space;
  assign pop     = (cnt != 2'd0) & out_rdy;
  assign out_vld = (cnt != 2'd0);
  assign out_dat = ent0;

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  // space resets low so nothing is accepted until the first clock after release
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt   <= 2'd0;
      space <= 1'b0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      cnt   <= cnt_nxt;
      space <= (cnt_nxt != 2'd2);
      if (pop) begin
        if (cnt == 2'd2) begin
          ent0 <= ent1;
        end else if (push) begin
          ent0 <= in_dat;
        end
      end else if (push) begin
        if (cnt == 2'd0) begin
          ent0 <= in_dat;
        end else begin
          ent1 <= in_dat;
        end
      end
    end
  end

endmodule

// File: rtl/axis_join.sv
// Joins one beat from each branch into {b1,b0}; 1-cycle latency via 2-entry skid buffer.
// Backpressure: input treadys see only tvalid/tuser/tlast and registered skid space, never m tready.
// AXIS_JOIN_RESYNC_EN adds a RESYNC state (drop until both branches start a frame) and drop_cnt.
module axis_join
  import axis_join_pkg::*;
#(
  parameter int DATA_WIDTH = 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [DATA_WIDTH*8-1:0]   s_axis_video_0_tdata,
  input  logic                      s_axis_video_0_tlast,
  input  logic                      s_axis_video_0_tuser,
  input  logic                      s_axis_video_0_tvalid,
  output logic                      s_axis_video_0_tready,
  input  logic [DATA_WIDTH*8-1:0]   s_axis_video_1_tdata,
  input  logic                      s_axis_video_1_tlast,
  input  logic                      s_axis_video_1_tuser,
  input  logic                      s_axis_video_1_tvalid,
  output logic                      s_axis_video_1_tready,
  output logic [2*DATA_WIDTH*8-1:0] m_axis_video_tdata,
  output logic                      m_axis_video_tlast,
  output logic                      m_axis_video_tuser,
  output logic                      m_axis_video_tvalid,
  input  logic                      m_axis_video_tready,
`ifdef AXIS_JOIN_RESYNC_EN
  output logic                      sync_err,
  output logic [15:0]               drop_cnt
`else
  output logic                      sync_err
`endif
);

  localparam int IW = DATA_WIDTH * 8;

  typedef struct packed {
    logic [2*IW-1:0] data;
    logic            last;
    logic            user;
  } entry_t;

  entry_t push_ent;
  entry_t head;
  logic   space;
  logic   push;
  logic   both_vld;
  logic   heads_match;

  assign both_vld    = s_axis_video_0_tvalid & s_axis_video_1_tvalid;
  assign heads_match = (s_axis_video_0_tuser == s_axis_video_1_tuser) &
                       (s_axis_video_0_tlast == s_axis_video_1_tlast);
  assign push_ent    = '{data: {s_axis_video_1_tdata, s_axis_video_0_tdata},
                         last: s_axis_video_0_tlast,
                         user: s_axis_video_0_tuser};

`ifdef AXIS_JOIN_RESYNC_EN
  state_t     state;
  logic       run_q;
  logic       mismatch;
  logic       drop0;
  logic       drop1;
  logic       resync_done;
  logic [1:0] n_drop;

  // run_q keeps RESYNC drops off while reset is asserted and for the release cycle
  assign push        = (state == JOIN) & both_vld & heads_match & space;
  assign mismatch    = run_q & (state == JOIN) & both_vld & ~heads_match;
  assign drop0       = run_q & (state == RESYNC) & s_axis_video_0_tvalid & ~s_axis_video_0_tuser;
  assign drop1       = run_q & (state == RESYNC) & s_axis_video_1_tvalid & ~s_axis_video_1_tuser;
  assign resync_done = run_q & (state == RESYNC) & both_vld &
                       s_axis_video_0_tuser & s_axis_video_1_tuser;
  assign n_drop      = {1'b0, drop0} + {1'b0, drop1};

  assign s_axis_video_0_tready = push | drop0;
  assign s_axis_video_1_tready = push | drop1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= RESYNC;
      run_q    <= 1'b0;
      sync_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      run_q    <= 1'b1;
      sync_err <= mismatch;
      drop_cnt <= sat_add16(drop_cnt, n_drop);
      if (state == JOIN) begin
        if (mismatch) state <= RESYNC;
      end else if (resync_done) begin
        state <= JOIN;
      end
    end
  end
`else
  // Mismatched pairs still join; branch 0 sideband wins and the error is flagged.
  assign push                  = both_vld & space;
  assign s_axis_video_0_tready = push;
  assign s_axis_video_1_tready = push;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync_err <= 1'b0;
    end else begin
      sync_err <= push & ~heads_match;
    end
  end
`endif

  axis_skid_buf #(
    .WIDTH($bits(entry_t))
  ) u_skid (
    .core_clk (aclk),
    .arst_n   (aresetn),
    .in_vld   (push),
    .in_dat   (push_ent),
    .space    (space),
    .out_vld  (m_axis_video_tvalid),
    .out_rdy  (m_axis_video_tready),
    .out_dat  (head)
  );

  assign m_axis_video_tdata = head.data;
  assign m_axis_video_tlast = head.last;
  assign m_axis_video_tuser = head.user;

endmodule

// File: tb/tb_axis_join.sv
// Bench for axis_join: directed steps plus a randomized stream against a queue-based pairing model.
// Builds with or without AXIS_JOIN_RESYNC_EN.
module tb_axis_join;
  import axis_join_pkg::*;

  typedef struct packed {
    logic [IN_W-1:0] d;
    logic            u;
    logic            l;
  } beat_t;

  logic              aclk    = 1'b0;
  logic              aresetn = 1'b0;
  logic [IN_W-1:0]   s0_d = '0, s1_d = '0;
  logic              s0_l = 1'b0, s0_u = 1'b0, s0_v = 1'b0, s0_r;
  logic              s1_l = 1'b0, s1_u = 1'b0, s1_v = 1'b0, s1_r;
  logic [OUT_W-1:0]  m_d;
  logic              m_l, m_u, m_v;
  logic              m_r = 1'b0;
  logic              sync_err;
`ifdef AXIS_JOIN_RESYNC_EN
  logic [15:0]       drop_cnt;
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif

  always #5 aclk = ~aclk;

  axis_join #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .aclk                  (aclk),
    .aresetn               (aresetn),
    .s_axis_video_0_tdata  (s0_d),
    .s_axis_video_0_tlast  (s0_l),
    .s_axis_video_0_tuser  (s0_u),
    .s_axis_video_0_tvalid (s0_v),
    .s_axis_video_0_tready (s0_r),
    .s_axis_video_1_tdata  (s1_d),
    .s_axis_video_1_tlast  (s1_l),
    .s_axis_video_1_tuser  (s1_u),
    .s_axis_video_1_tvalid (s1_v),
    .s_axis_video_1_tready (s1_r),
    .m_axis_video_tdata    (m_d),
    .m_axis_video_tlast    (m_l),
    .m_axis_video_tuser    (m_u),
    .m_axis_video_tvalid   (m_v),
    .m_axis_video_tready   (m_r),
`ifdef AXIS_JOIN_RESYNC_EN
    .sync_err              (sync_err),
    .drop_cnt              (drop_cnt)
`else
    .sync_err              (sync_err)
`endif
  );

  int errors = 0;
  int checks = 0;

  beat_t       s0[$];
  beat_t       s1[$];
  skid_entry_t exp_q[$];
  int          p0, p1, n_sync;
  bit          ov0, ov1, chk_pair;
  logic        r0, r1, mv, se;
  bit          prev_hold;
  skid_entry_t prev_ent;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic beat_t mk(input logic [IN_W-1:0] d, input logic u, input logic l);
    beat_t b;
    b.d = d; b.u = u; b.l = l;
    return b;
  endfunction

  // Joined beat is the two branch beats side by side, sideband from branch 0.
  task automatic add_pair(input beat_t b0, input beat_t b1);
    skid_entry_t e;
    s0.push_back(b0);
    s1.push_back(b1);
    e.data = {b1.d, b0.d};
    e.last = b0.l;
    e.user = b0.u;
    exp_q.push_back(e);
  endtask

  task automatic clear_model();
    s0.delete(); s1.delete(); exp_q.delete();
    p0 = 0; p1 = 0; ov0 = 0; ov1 = 0; prev_hold = 0;
  endtask

  // One clock: offer beats, sample at negedge+1, score, advance on handshakes.
  task automatic eng(input bit en0, input bit en1, input bit rdy);
    skid_entry_t cur;
    ov0 = (p0 < s0.size()) && (ov0 || en0);
    ov1 = (p1 < s1.size()) && (ov1 || en1);
    if (ov0) begin s0_v = 1; s0_d = s0[p0].d; s0_u = s0[p0].u; s0_l = s0[p0].l; end
    else     begin s0_v = 0; s0_d = '0; s0_u = 0; s0_l = 0; end
    if (ov1) begin s1_v = 1; s1_d = s1[p1].d; s1_u = s1[p1].u; s1_l = s1[p1].l; end
    else     begin s1_v = 0; s1_d = '0; s1_u = 0; s1_l = 0; end
    m_r = rdy;
    #1;
    r0 = s0_r; r1 = s1_r; mv = m_v; se = sync_err;
    cur.data = m_d; cur.last = m_l; cur.user = m_u;
    if (chk_pair) begin
      chk("pair_rdy", 32'(r0), 32'(r1));
      chk("rdy_needs_both", 32'(r0 & ~(s0_v & s1_v)), 32'(0));
    end
    if (se) n_sync++;
    if (prev_hold) chk("out_hold", 32'({mv, cur}), 32'({1'b1, prev_ent}));
    if (mv && rdy) begin
      chk("out_present", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        chk("out_beat", 32'(cur), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
    prev_hold = mv && !rdy;
    prev_ent  = cur;
    if (ov0 && r0) begin p0++; ov0 = 0; end
    if (ov1 && r1) begin p1++; ov1 = 0; end
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic do_reset();
    aresetn = 0;
    s0_v = 1; s0_u = 0; s0_l = 0; s1_v = 1; s1_u = 0; s1_l = 0; m_r = 1;
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_rdy0", 32'(s0_r), 32'(0));
    chk("rst_rdy1", 32'(s1_r), 32'(0));
    chk("rst_out", 32'({m_v, m_d, m_l, m_u}), 32'(0));
    chk("rst_sync", 32'(sync_err), 32'(0));
`ifdef AXIS_JOIN_RESYNC_EN
    chk("rst_drop", 32'(drop_cnt), 32'(0));
`endif
    aresetn = 1;
    s0_v = 0; s1_v = 0;
    clear_model();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b0, b1;
    int    sb;
    chk_pair = 1;
    n_sync   = 0;

    // reset state
    do_reset();

    // 8 matched beats at full rate
    for (int i = 0; i < 8; i++)
      add_pair(mk(8'(8'h10 + i), i == 0, i == 7), mk(8'(8'h20 + i), i == 0, i == 7));
    for (int i = 0; i < 10 + OFS; i++) begin
      eng(1, 1, 1);
      chk("t2_rdy", 32'(r0), 32'(i >= OFS && i < 8 + OFS));
      chk("t2_vld", 32'(mv), 32'(i >= 1 + OFS && i <= 8 + OFS));
    end
    chk("t2_drained", 32'(exp_q.size()), 32'(0));

    // branch 1 late: nothing consumed until both valid
    clear_model();
    add_pair(mk(8'h31, 0, 0), mk(8'h41, 0, 0));
    for (int i = 0; i < 5; i++) begin
      eng(1, 0, 1);
      chk("t3_rdy0", 32'(r0), 32'(0));
      chk("t3_rdy1", 32'(r1), 32'(0));
      chk("t3_novld", 32'(mv), 32'(0));
    end
    eng(1, 1, 1);
    chk("t3_join", 32'(r0), 32'(1));
    eng(0, 0, 1);
    chk("t3_lat", 32'(mv), 32'(1));
    chk("t3_drained", 32'(exp_q.size()), 32'(0));

    // downstream stall: two beats buffered, then hold
    clear_model();
    for (int i = 0; i < 6; i++)
      add_pair(mk(8'(8'h50 + i), 0, i == 5), mk(8'(8'h60 + i), 0, i == 5));
    for (int k = 0; k < 4; k++) begin
      eng(1, 1, 0);
      chk("t4_rdy", 32'(r0), 32'(k < 2));
      chk("t4_vld", 32'(mv), 32'(k >= 1));
    end
    chk("t4_acc", 32'(p0), 32'(2));
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) eng(1, 1, 1);
    chk("t4_drained", 32'(exp_q.size()), 32'(0));
    chk("t4_consumed", 32'(p0), 32'(6));

`ifdef AXIS_JOIN_RESYNC_EN
    // drop leading non-SOF beats on branch 0
    do_reset();
    chk_pair = 0;
    s0.push_back(mk(8'h01, 0, 0));
    s0.push_back(mk(8'h02, 0, 0));
    s0.push_back(mk(8'h03, 0, 0));
    add_pair(mk(8'hA0, 1, 0), mk(8'hB0, 1, 0));
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) eng(1, 1, 1);
    chk("m1_out", 32'(exp_q.size()), 32'(0));
    chk("m1_drop", 32'(drop_cnt), 32'(3));
    chk("m1_cons0", 32'(p0), 32'(4));

    // tlast misaligned: resync at next frame start
    clear_model();
    sb = n_sync;
    begin
      logic [15:0] db;
      db = drop_cnt;
      add_pair(mk(8'h70, 1, 0), mk(8'h80, 1, 0));
      add_pair(mk(8'h71, 0, 0), mk(8'h81, 0, 0));
      add_pair(mk(8'h72, 0, 0), mk(8'h82, 0, 0));
      s0.push_back(mk(8'h73, 0, 1)); s1.push_back(mk(8'h83, 0, 0));
      s0.push_back(mk(8'h74, 0, 0)); s1.push_back(mk(8'h84, 0, 1));
      add_pair(mk(8'h75, 1, 0), mk(8'h85, 1, 0));
      add_pair(mk(8'h76, 0, 0), mk(8'h86, 0, 0));
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) eng(1, 1, 1);
      eng(0, 0, 1);
      chk("m2_out", 32'(exp_q.size()), 32'(0));
      chk("m2_sync", 32'(n_sync - sb), 32'(1));
      chk("m2_drop", 32'(drop_cnt - db), 32'(4));
      chk("m2_cons", 32'(p0), 32'(7));
    end
    chk_pair = 1;
`else
    // mismatch joins anyway with branch 0 sideband, sync_err pulses once
    clear_model();
    sb = n_sync;
    add_pair(mk(8'h77, 0, 1), mk(8'h88, 0, 0));
    eng(1, 1, 1);
    chk("t5_rdy", 32'(r0), 32'(1));
    chk("t5_sync0", 32'(se), 32'(0));
    eng(0, 0, 1);
    chk("t5_sync1", 32'(se), 32'(1));
    chk("t5_vld", 32'(mv), 32'(1));
    eng(0, 0, 1);
    chk("t5_sync2", 32'(se), 32'(0));
    chk("t5_drained", 32'(exp_q.size()), 32'(0));
    chk("t5_pulses", 32'(n_sync - sb), 32'(1));
`endif

    // randomized matched streams with random gaps and backpressure
    do_reset();
    for (int i = 0; i < 40; i++) begin
      b0 = mk(8'($urandom), (i % 16) == 0, (i % 8) == 7);
      b1 = mk(8'($urandom), (i % 16) == 0, (i % 8) == 7);
      add_pair(b0, b1);
    end
    for (int c = 0; c < 2000 && exp_q.size() != 0; c++)
      eng($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    chk("rand_drained", 32'(exp_q.size()), 32'(0));
    chk("rand_cons0", 32'(p0), 32'(40));
    chk("rand_cons1", 32'(p1), 32'(40));

    // async reset with two buffered beats
    do_reset();
    for (int i = 0; i < 4; i++) add_pair(mk(8'(8'h90 + i), i == 0, 0), mk(8'(8'hC0 + i), i == 0, 0));
    repeat (3 + OFS) eng(1, 1, 0);
    chk("t6_acc", 32'(p0), 32'(2));
    chk("t6_full", 32'(mv), 32'(1));
    #2 aresetn = 0;
    #1;
    chk("t6_async_vld", 32'(m_v), 32'(0));
    chk("t6_async_rdy", 32'({s0_r, s1_r}), 32'(0));
    @(negedge aclk);
    aresetn = 1;
    clear_model();
    for (int i = 0; i < 5; i++) begin
      eng(0, 0, 1);
      chk("t6_no_stale", 32'(mv), 32'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_join.md
Name: axis_join

Overview:
Two-input AXI4-Stream video join. It is the merge counterpart to the stream splitter.
- Pairs one beat from each input and emits a single beat with concatenated tdata. Used to recombine two filter branches that were fed from a common split.
- Registered output through a 2-entry skid buffer; full throughput, no combinational path from m_axis_video_tready to the input treadys.
- Detects frame/line misalignment between the branches.

Parameters:
DATA_WIDTH, 1, bytes per input beat; output tdata is 2*DATA_WIDTH bytes.

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  asynchronous active-low reset
s_axis_video_0_tdata  in  DATA_WIDTH*8  branch 0 pixel data
s_axis_video_0_tlast  in  1  branch 0 end of line
s_axis_video_0_tuser  in  1  branch 0 start of frame
s_axis_video_0_tvalid  in  1  branch 0 valid
s_axis_video_0_tready  out  1  branch 0 ready
s_axis_video_1_tdata/tlast/tuser/tvalid/tready  same as branch 0, for branch 1
m_axis_video_tdata  out  2*DATA_WIDTH*8  {branch1 data, branch0 data}
m_axis_video_tlast  out  1  end of line
m_axis_video_tuser  out  1  start of frame
m_axis_video_tvalid  out  1  output valid
m_axis_video_tready  in  1  downstream ready
sync_err  out  1  one-cycle pulse on detected misalignment

Behaviour:
- Reset (async assert, sync release): skid buffer empty, m_axis_video_tvalid=0, m tdata/tlast/tuser=0, sync_err=0, both s treadys=0.
- Reset state is RESYNC with the macro, JOIN without it.
- space = skid buffer holds fewer than 2 entries. Computed from registered occupancy only.
- JOIN, both inputs valid, heads match (tuser0==tuser1 and tlast0==tlast1), space=1:
  - Both treadys=1 in the same cycle; exactly one beat consumed from each input.
  - Entry pushed: tdata={d1,d0}, tuser=tuser0, tlast=tlast0.
- JOIN, only one input valid, or space=0: both treadys=0. A beat is never consumed from one side alone.
- Mismatch (JOIN, both valid, tuser or tlast differ): sync_err pulses for one cycle on the cycle after detection. The response then depends on the macro (see Optional Feature).
- Output: m_axis_video_tvalid = buffer non-empty; head popped on tvalid&tready.
  - Latency: input handshake to m_axis_video_tvalid is 1 cycle.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - Buffer full with m_axis_video_tready=0: inputs stalled, output data held stable.
- AXIS rules: output data/user/last are stable while tvalid=1 and tready=0. Input tready may depend on input tvalid.
- Reset asserted mid-frame: buffered beats are discarded, no partial output. With the macro, state returns to RESYNC so output restarts at a frame boundary.

Optional Feature:
Macro AXIS_JOIN_RESYNC_EN.
- Defined: state machine with states JOIN and RESYNC.
  - A mismatch moves JOIN->RESYNC. The mismatched beats are not consumed on the transition cycle.
  - In RESYNC, each input is handled independently:
    - Valid with tuser=0: tready=1 and the beat is dropped.
    - Valid with tuser=1: tready=0 and the beat is held.
  - RESYNC->JOIN once both inputs present valid tuser=1. The pair is joined in JOIN on the following cycle.
  - Adds 16-bit output drop_cnt: beats dropped since reset, saturating at 0xFFFF.
- Undefined: no RESYNC state and no drop_cnt port.
  - Mismatched pairs are joined anyway using branch 0 tuser/tlast.
  - sync_err still pulses.

Decomposition:
- Package axis_join_pkg holds:
  - state enum {JOIN, RESYNC};
  - localparams IN_W=DATA_WIDTH*8 and OUT_W=2*IN_W;
  - packed struct for a skid entry {data, last, user}.
- One sub-module, axis_skid_buf: 2-entry register slice parameterised on width, exposing registered "space".

Test Plan:
- Both inputs stream 8 matched beats (d0=0x10..0x17, d1=0x20..0x27, tlast on beat 7), m_axis_video_tready=1 -> 8 outputs 0x2010..0x2717, one per cycle after 1-cycle latency, tlast only on the 8th.
- Branch 1 tvalid held low 5 cycles while branch 0 valid -> both treadys=0, no output. Branch 1 then valid -> joined beat appears 1 cycle later.
- m_axis_video_tready=0 for 4 cycles with both inputs valid -> exactly 2 beats accepted, then treadys=0, output stable. Release -> remaining beats drain in order, nothing lost or duplicated.
- Macro on, from reset:
  - stimulus: branch 0 sends 3 beats with tuser=0 then tuser=1 (0xA0); branch 1 sends tuser=1 (0xB0) immediately;
  - response: 3 beats dropped, drop_cnt=3, first output 0xB0A0 with tuser=1.
- Macro on, branch 0 tlast on beat 4, branch 1 tlast on beat 5 -> sync_err pulse on the mismatch. No output until both present tuser=1, then joining resumes.
- aresetn asserted while skid buffer holds 2 entries -> m_axis_video_tvalid=0 immediately (async). After release, no stale data is emitted.
